pdm_rx_sched: RTL and testbench
===============================

// Module: pdm_rx_sched
// PURPOSE
//  Run-time controller for the PDM receive path. Shadows the PDM config, sequences enable/warm-up/drain,
//  checks the channel order of decimator samples, packs 16b PCM into 32b words, and buffers them toward
//  the uDMA RX stream with valid/ready backpressure. Sits between the cfg regfile and the PDM front-end/CIC.
// PARAMETERS
//  FIFO_DEPTH   4   output FIFO entries (power of 2, >=2)
//  WARMUP_W     4   width of warm-up frame counter
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   synchronous active-high reset
//  cfg_en_i          in   1   receive enable (level)
//  cfg_ch_mode_i     in   2   00=1ch 01=2ch rise/fall 10=2ch sep 11=4ch
//  cfg_decimation_i  in   10  CIC decimation
//  cfg_shift_i       in   3   CIC output shift
//  cfg_warmup_i      in   WARMUP_W  frames discarded after enable
//  cfg_pack_i        in   1   1: two samples per 32b word; 0: one sample, zero-extended
//  pdm_en_o          out  1   enable to front-end/CIC
//  pdm_ch_mode_o     out  2   shadowed mode
//  pdm_decimation_o  out  10  shadowed decimation
//  pdm_shift_o       out  3   shadowed shift
//  pcm_data_i        in   16  decimated sample
//  pcm_ch_i          in   2   channel tag of sample
//  pcm_valid_i       in   1   sample strobe (no backpressure upstream)
//  data_o            out  32  word to uDMA
//  data_valid_o      out  1   word valid
//  data_ready_i      in   1   uDMA accepts word
//  busy_o            out  1   state != IDLE
//  ovf_o             out  1   sticky: sample dropped on full FIFO
//  sync_err_o        out  1   sticky: channel tag out of order
//  err_clr_i         in   1   clears ovf_o and sync_err_o
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; shadows 0; FIFO empty; pack half and counters cleared.
//  NCH: mode 00->1, 01/10->2, 11->4. Frame = samples ch0..NCH-1 in order.
//  IDLE: pdm_en_o=0. cfg_en_i=1 -> latch all cfg_* into shadows, go WARMUP (RUN if cfg_warmup_i==0);
//   pdm_en_o=1 from the next cycle. Shadows never change outside IDLE.
//  WARMUP: samples discarded; count frames (sample with ch==NCH-1); count==warmup -> RUN.
//  RUN: expected ch exp starts 0. pcm_valid_i & pcm_ch_i==exp -> accept, exp=(exp+1)%NCH.
//   Mismatch -> drop, set sync_err_o, enter RESYNC: drop until a ch0 sample, which is accepted.
//  Packing: pack=0 -> write {16'h0,s} per sample. pack=1 -> first sample held as low half, write
//   {s2,s1} on second. Write happens at edge following accept; data_valid_o = !empty (1-cycle latency).
//  FIFO: write allowed if !full or a pop occurs same cycle. Pop when data_valid_o & data_ready_i.
//   data_o/data_valid_o stable while stalled.
//  Overflow: write needed and not allowed -> drop word, set ovf_o, clear pack half, RESYNC (resume at ch0).
//  cfg_en_i=0 in WARMUP/RUN/RESYNC -> DRAIN: pdm_en_o=0 next cycle; incoming samples dropped;
//   pending pack half written as {16'h0,s1} (if space, else dropped with ovf_o); wait FIFO empty -> IDLE.
//   cfg_en_i=1 again during DRAIN is ignored until IDLE reached.
//  Sticky flags: set and err_clr_i same cycle -> set wins. rst_i mid-operation -> full reset, FIFO flushed.
// STRUCTURE
//  pdm_pkg: pdm_mode_e enum (1CH, 2CH_RF, 2CH_SEP, 4CH), rx_state_e (IDLE,WARMUP,RUN,RESYNC,DRAIN),
//   function nch(pdm_mode_e). Sub-module pdm_rx_fifo: sync FIFO, 32b x FIFO_DEPTH, push/pop/full/empty.
// TESTING
//  1ch, warmup=0, pack=0, ready=1: samples 0x1234,0x5678 -> data_o 0x00001234 then 0x00005678, 1 cycle each.
//  4ch, warmup=2, pack=1: 8 samples discarded, then ch0..3 = A,B,C,D -> words {B,A},{D,C}.
//  2ch, tags 0,0,1: 2nd ch0 -> sync_err_o=1, dropped; sample 3 (ch1) dropped until next ch0 accepted.
//  pack=0, ready=0, FIFO_DEPTH+1 samples -> ovf_o=1, FIFO holds first 4; stays set until err_clr_i.
//  pack=1, one sample 0xBEEF then cfg_en_i=0 -> pdm_en_o=0 next cycle, word 0x0000BEEF, busy_o drops.
//  Change cfg_decimation_i while RUN -> pdm_decimation_o unchanged until disable/IDLE/re-enable.

Source files
------------

// File: rtl/pdm_rx_sched_pkg.sv
// Shared types for the PDM receive scheduler: channel modes, controller states and
// the frame-size helper.
package pdm_rx_sched_pkg;

   typedef enum logic [1:0] {
      Mode1Ch    = 2'b00,
      Mode2ChRf  = 2'b01,
      Mode2ChSep = 2'b10,
      Mode4Ch    = 2'b11
   } pdm_mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StWarmup,
      StRun,
      StResync,
      StDrain
   } rx_state_e;

   // Number of channels in one frame for a given mode.
   function automatic logic [2:0] nch(input pdm_mode_e mode);
      case (mode)
         Mode1Ch: return 3'd1;
         Mode4Ch: return 3'd4;
         default: return 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/pdm_rx_sched_fifo.sv
// Synchronous FIFO for packed PCM words; read data reads as zero while empty.
module pdm_rx_sched_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign empty_o   = (r_wr_ptr == r_rd_ptr);
   assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is legal only when an entry leaves in the same cycle.
   assign w_do_push = push_i && (!full_o || w_do_pop);
   assign rdata_o   = empty_o ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/pdm_rx_sched.sv
// PDM receive run-time controller: config shadowing, enable/warm-up/drain sequencing,
// channel-order checking, 16b->32b packing and output buffering toward the uDMA.
module pdm_rx_sched
   import pdm_rx_sched_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WARMUP_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_en_i,
   input  logic [1:0]          cfg_ch_mode_i,
   input  logic [9:0]          cfg_decimation_i,
   input  logic [2:0]          cfg_shift_i,
   input  logic [WARMUP_W-1:0] cfg_warmup_i,
   input  logic                cfg_pack_i,
   output logic                pdm_en_o,
   output logic [1:0]          pdm_ch_mode_o,
   output logic [9:0]          pdm_decimation_o,
   output logic [2:0]          pdm_shift_o,
   input  logic [15:0]         pcm_data_i,
   input  logic [1:0]          pcm_ch_i,
   input  logic                pcm_valid_i,
   output logic [31:0]         data_o,
   output logic                data_valid_o,
   input  logic                data_ready_i,
   output logic                busy_o,
   output logic                ovf_o,
   output logic                sync_err_o,
   input  logic                err_clr_i
);

   rx_state_e           r_state, w_state_d;
   pdm_mode_e           r_mode, w_mode_d;
   logic [9:0]          r_dec, w_dec_d;
   logic [2:0]          r_shift, w_shift_d;
   logic [WARMUP_W-1:0] r_warmup, w_warmup_d;
   logic                r_pack, w_pack_d;
   logic [WARMUP_W-1:0] r_wcnt, w_wcnt_d, w_wcnt_inc;
   logic [1:0]          r_exp, w_exp_d;
   logic                r_half_vld, w_half_vld_d;
   logic [15:0]         r_half, w_half_d;
   logic                r_ovf, r_sync_err;

   logic [1:0]  w_last_ch;
   logic [1:0]  w_exp_next;
   logic        w_accept;
   logic        w_need_wr;
   logic [31:0] w_wr_word;
   logic        w_push;
   logic [31:0] w_wdata;
   logic        w_pop;
   logic        w_space;
   logic        w_ovf_set;
   logic        w_sync_set;
   logic        w_fifo_full;
   logic        w_fifo_empty;
   logic [31:0] w_fifo_rdata;

   assign w_last_ch  = 2'(nch(r_mode) - 3'd1);
   assign w_exp_next = (r_exp == w_last_ch) ? 2'd0 : r_exp + 2'd1;
   assign w_wcnt_inc = r_wcnt + WARMUP_W'(1);
   assign w_pop      = !w_fifo_empty && data_ready_i;
   assign w_space    = !w_fifo_full || w_pop;

   always_comb begin
      w_state_d    = r_state;
      w_mode_d     = r_mode;
      w_dec_d      = r_dec;
      w_shift_d    = r_shift;
      w_warmup_d   = r_warmup;
      w_pack_d     = r_pack;
      w_wcnt_d     = r_wcnt;
      w_exp_d      = r_exp;
      w_half_vld_d = r_half_vld;
      w_half_d     = r_half;
      w_accept     = 1'b0;
      w_need_wr    = 1'b0;
      w_wr_word    = '0;
      w_push       = 1'b0;
      w_wdata      = '0;
      w_ovf_set    = 1'b0;
      w_sync_set   = 1'b0;

      case (r_state)
         StIdle: begin
            if (cfg_en_i) begin
               w_mode_d     = pdm_mode_e'(cfg_ch_mode_i);
               w_dec_d      = cfg_decimation_i;
               w_shift_d    = cfg_shift_i;
               w_warmup_d   = cfg_warmup_i;
               w_pack_d     = cfg_pack_i;
               w_wcnt_d     = '0;
               w_exp_d      = 2'd0;
               w_half_vld_d = 1'b0;
               w_state_d    = (cfg_warmup_i == '0) ? StRun : StWarmup;
            end
         end
         StWarmup: begin
            if (!cfg_en_i) begin
               w_state_d = StDrain;
            end else if (pcm_valid_i && (pcm_ch_i == w_last_ch)) begin
               w_wcnt_d = w_wcnt_inc;
               if (w_wcnt_inc == r_warmup) begin
                  w_exp_d   = 2'd0;
                  w_state_d = StRun;
               end
            end
         end
         StRun: begin
            if (!cfg_en_i) begin
               w_state_d = StDrain;
            end else if (pcm_valid_i) begin
               if (pcm_ch_i == r_exp) begin
                  w_accept = 1'b1;
                  w_exp_d  = w_exp_next;
               end else begin
                  w_sync_set = 1'b1;
                  w_state_d  = StResync;
               end
            end
         end
         StResync: begin
            if (!cfg_en_i) begin
               w_state_d = StDrain;
            end else if (pcm_valid_i && (pcm_ch_i == 2'd0)) begin
               w_accept  = 1'b1;
               w_exp_d   = (w_last_ch == 2'd0) ? 2'd0 : 2'd1;
               w_state_d = StRun;
            end
         end
         StDrain: begin
            // Flush a lone pending half first, then wait for the uDMA to empty the FIFO.
            if (r_half_vld) begin
               if (w_space) begin
                  w_push  = 1'b1;
                  w_wdata = {16'h0, r_half};
               end else begin
                  w_ovf_set = 1'b1;
               end
               w_half_vld_d = 1'b0;
            end else if (w_fifo_empty) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_accept) begin
         if (!r_pack) begin
            w_need_wr = 1'b1;
            w_wr_word = {16'h0, pcm_data_i};
         end else if (!r_half_vld) begin
            w_half_vld_d = 1'b1;
            w_half_d     = pcm_data_i;
         end else begin
            w_need_wr    = 1'b1;
            w_wr_word    = {pcm_data_i, r_half};
            w_half_vld_d = 1'b0;
         end
      end

      // Overflow loses frame alignment, so restart packing from a ch0 sample.
      if (w_need_wr) begin
         if (w_space) begin
            w_push  = 1'b1;
            w_wdata = w_wr_word;
         end else begin
            w_ovf_set    = 1'b1;
            w_half_vld_d = 1'b0;
            w_state_d    = StResync;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= StIdle;
         r_mode     <= Mode1Ch;
         r_dec      <= '0;
         r_shift    <= '0;
         r_warmup   <= '0;
         r_pack     <= 1'b0;
         r_wcnt     <= '0;
         r_exp      <= 2'd0;
         r_half_vld <= 1'b0;
         r_half     <= '0;
         r_ovf      <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_mode     <= w_mode_d;
         r_dec      <= w_dec_d;
         r_shift    <= w_shift_d;
         r_warmup   <= w_warmup_d;
         r_pack     <= w_pack_d;
         r_wcnt     <= w_wcnt_d;
         r_exp      <= w_exp_d;
         r_half_vld <= w_half_vld_d;
         r_half     <= w_half_d;
         r_ovf      <= w_ovf_set || (r_ovf && !err_clr_i);
         r_sync_err <= w_sync_set || (r_sync_err && !err_clr_i);
      end
   end

   pdm_rx_sched_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (32)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .wdata_i (w_wdata),
      .pop_i   (w_pop),
      .rdata_o (w_fifo_rdata),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

   assign pdm_en_o         = (r_state == StWarmup) || (r_state == StRun) ||
                             (r_state == StResync);
   assign pdm_ch_mode_o    = r_mode;
   assign pdm_decimation_o = r_dec;
   assign pdm_shift_o      = r_shift;
   assign data_o           = w_fifo_rdata;
   assign data_valid_o     = !w_fifo_empty;
   assign busy_o           = (r_state != StIdle);
   assign ovf_o            = r_ovf;
   assign sync_err_o       = r_sync_err;

endmodule

// File: tb/tb_pdm_rx_sched.sv
// Directed bench for pdm_rx_sched; expected uDMA words are queued when samples are
// driven and compared in order as each word is handed over.
module tb_pdm_rx_sched;

   logic        clk;
   logic        rst_i;
   logic        cfg_en_i;
   logic [1:0]  cfg_ch_mode_i;
   logic [9:0]  cfg_decimation_i;
   logic [2:0]  cfg_shift_i;
   logic [3:0]  cfg_warmup_i;
   logic        cfg_pack_i;
   logic        pdm_en_o;
   logic [1:0]  pdm_ch_mode_o;
   logic [9:0]  pdm_decimation_o;
   logic [2:0]  pdm_shift_o;
   logic [15:0] pcm_data_i;
   logic [1:0]  pcm_ch_i;
   logic        pcm_valid_i;
   logic [31:0] data_o;
   logic        data_valid_o;
   logic        data_ready_i;
   logic        busy_o;
   logic        ovf_o;
   logic        sync_err_o;
   logic        err_clr_i;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];

   pdm_rx_sched #(
      .FIFO_DEPTH (4),
      .WARMUP_W   (4)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .cfg_en_i         (cfg_en_i),
      .cfg_ch_mode_i    (cfg_ch_mode_i),
      .cfg_decimation_i (cfg_decimation_i),
      .cfg_shift_i      (cfg_shift_i),
      .cfg_warmup_i     (cfg_warmup_i),
      .cfg_pack_i       (cfg_pack_i),
      .pdm_en_o         (pdm_en_o),
      .pdm_ch_mode_o    (pdm_ch_mode_o),
      .pdm_decimation_o (pdm_decimation_o),
      .pdm_shift_o      (pdm_shift_o),
      .pcm_data_i       (pcm_data_i),
      .pcm_ch_i         (pcm_ch_i),
      .pcm_valid_i      (pcm_valid_i),
      .data_o           (data_o),
      .data_valid_o     (data_valid_o),
      .data_ready_i     (data_ready_i),
      .busy_o           (busy_o),
      .ovf_o            (ovf_o),
      .sync_err_o       (sync_err_o),
      .err_clr_i        (err_clr_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_checks++;
      assert (obs === req) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, req);
      end
   endtask

   // One clock: handshake is sampled mid-cycle, inputs change 1 time unit after the edge.
   task automatic cyc();
      logic [31:0] want;
      @(negedge clk);
      if (data_valid_o && data_ready_i) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL unexpected_word: observed=%h expected=none", data_o);
         end
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("sb_word", data_o, want);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] ch, input logic [15:0] d);
      pcm_valid_i = 1'b1;
      pcm_ch_i    = ch;
      pcm_data_i  = d;
      cyc();
      pcm_valid_i = 1'b0;
   endtask

   task automatic start(input logic [1:0] mode, input logic [9:0] dec, input logic [3:0] warm,
                        input logic pack);
      cfg_ch_mode_i    = mode;
      cfg_decimation_i = dec;
      cfg_shift_i      = 3'd3;
      cfg_warmup_i     = warm;
      cfg_pack_i       = pack;
      cfg_en_i         = 1'b1;
      cyc();
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && busy_o; i++) cyc();
      check("idle_timeout", {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      rst_i = 1'b1; cfg_en_i = 1'b0; cfg_ch_mode_i = 2'd0; cfg_decimation_i = '0;
      cfg_shift_i = '0; cfg_warmup_i = '0; cfg_pack_i = 1'b0; pcm_data_i = '0;
      pcm_ch_i = '0; pcm_valid_i = 1'b0; data_ready_i = 1'b1; err_clr_i = 1'b0;
      cyc(); cyc();
      check("rst_pdm_en", {31'd0, pdm_en_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_valid", {31'd0, data_valid_o}, 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_ovf", {31'd0, ovf_o}, 32'd0);
      check("rst_sync", {31'd0, sync_err_o}, 32'd0);
      check("rst_dec", {22'd0, pdm_decimation_o}, 32'd0);
      check("rst_shift", {29'd0, pdm_shift_o}, 32'd0);
      rst_i = 1'b0;
      cyc();

      // 1ch, no warm-up, unpacked
      start(2'b00, 10'd64, 4'd0, 1'b0);
      check("t1_pdm_en", {31'd0, pdm_en_o}, 32'd1);
      check("t1_busy", {31'd0, busy_o}, 32'd1);
      check("t1_dec", {22'd0, pdm_decimation_o}, 32'd64);
      check("t1_shift", {29'd0, pdm_shift_o}, 32'd3);
      exp_q.push_back(32'h0000_1234); send(2'd0, 16'h1234);
      check("t1_valid_latency", {31'd0, data_valid_o}, 32'd1);
      exp_q.push_back(32'h0000_5678); send(2'd0, 16'h5678);
      cyc();
      check("t1_valid_clear", {31'd0, data_valid_o}, 32'd0);
      cfg_en_i = 1'b0;
      cyc();
      check("t1_pdm_en_off", {31'd0, pdm_en_o}, 32'd0);
      wait_idle(10);

      // 4ch, warm-up of two frames, packed
      start(2'b11, 10'd32, 4'd2, 1'b1);
      check("t2_mode", {30'd0, pdm_ch_mode_o}, 32'd3);
      for (int f = 0; f < 2; f++)
         for (int c = 0; c < 4; c++) send(2'(c), 16'hDEAD);
      send(2'd0, 16'hAAAA);
      check("t2_half_held", {31'd0, data_valid_o}, 32'd0);
      exp_q.push_back(32'hBBBB_AAAA); send(2'd1, 16'hBBBB);
      send(2'd2, 16'hCCCC);
      exp_q.push_back(32'hDDDD_CCCC); send(2'd3, 16'hDDDD);
      cyc(); cyc();
      cfg_en_i = 1'b0;
      wait_idle(10);

      // 2ch, out-of-order tag then resync on ch0
      start(2'b10, 10'd16, 4'd0, 1'b0);
      exp_q.push_back(32'h0000_0001); send(2'd0, 16'h0001);
      send(2'd0, 16'h0002);
      check("t3_sync_set", {31'd0, sync_err_o}, 32'd1);
      send(2'd1, 16'h0003);
      exp_q.push_back(32'h0000_0004); send(2'd0, 16'h0004);
      exp_q.push_back(32'h0000_0005); send(2'd1, 16'h0005);
      check("t3_sync_sticky", {31'd0, sync_err_o}, 32'd1);
      err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
      check("t3_sync_clr", {31'd0, sync_err_o}, 32'd0);
      cfg_en_i = 1'b0;
      wait_idle(10);

      // Overflow with the uDMA stalled
      data_ready_i = 1'b0;
      start(2'b00, 10'd8, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back(32'h0000_0010 + 32'(i));
         send(2'd0, 16'h0010 + 16'(i));
      end
      check("t4_ovf_set", {31'd0, ovf_o}, 32'd1);
      check("t4_head", data_o, 32'h0000_0010);
      cyc(); cyc();
      check("t4_stall_valid", {31'd0, data_valid_o}, 32'd1);
      check("t4_stall_data", data_o, 32'h0000_0010);
      check("t4_ovf_sticky", {31'd0, ovf_o}, 32'd1);
      err_clr_i = 1'b1; send(2'd0, 16'h0099); err_clr_i = 1'b0;
      check("t4_set_wins", {31'd0, ovf_o}, 32'd1);
      err_clr_i = 1'b1; cyc(); err_clr_i = 1'b0;
      check("t4_ovf_clr", {31'd0, ovf_o}, 32'd0);
      data_ready_i = 1'b1;
      cfg_en_i = 1'b0;
      wait_idle(20);

      // Packed half flushed by disable
      start(2'b00, 10'd8, 4'd0, 1'b1);
      send(2'd0, 16'hBEEF);
      exp_q.push_back(32'h0000_BEEF);
      cfg_en_i = 1'b0;
      cyc();
      check("t5_pdm_en_off", {31'd0, pdm_en_o}, 32'd0);
      check("t5_busy_drain", {31'd0, busy_o}, 32'd1);
      wait_idle(10);
      check("t5_ovf", {31'd0, ovf_o}, 32'd0);

      // Shadow registers ignore config changes outside IDLE
      start(2'b00, 10'd100, 4'd0, 1'b0);
      cfg_decimation_i = 10'd200;
      cfg_ch_mode_i    = 2'b11;
      cyc(); cyc();
      check("t6_dec_hold", {22'd0, pdm_decimation_o}, 32'd100);
      check("t6_mode_hold", {30'd0, pdm_ch_mode_o}, 32'd0);
      cfg_en_i = 1'b0;
      wait_idle(10);
      cyc();
      check("t6_dec_idle", {22'd0, pdm_decimation_o}, 32'd100);
      cfg_en_i = 1'b1;
      cyc();
      check("t6_dec_new", {22'd0, pdm_decimation_o}, 32'd200);

      // Reset mid-operation flushes the FIFO
      data_ready_i = 1'b0;
      cfg_ch_mode_i = 2'b00;
      send(2'd0, 16'h7777);
      check("t7_valid_pre", {31'd0, data_valid_o}, 32'd1);
      rst_i = 1'b1; cyc(); rst_i = 1'b0;
      check("t7_valid_flush", {31'd0, data_valid_o}, 32'd0);
      check("t7_busy", {31'd0, busy_o}, 32'd0);
      check("t7_dec", {22'd0, pdm_decimation_o}, 32'd0);
      cfg_en_i = 1'b0;
      data_ready_i = 1'b1;
      cyc();
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
